// File: rtl/ifetch_pkg.sv
// Shared widths and types for the instruction fetch stage.
package ifetch_pkg;
  localparam int ALEN = 32;
  localparam int ILEN = 32;

  typedef struct packed {
    logic            exception;
    logic [ILEN-1:0] instr;
    logic [ALEN-1:0] addr;
  } fetch_entry_t;

  typedef enum logic {FETCH, HALTED} ifetch_state_t;
endpackage

// File: rtl/ifetch_if.sv
// Instruction memory port: in-order requests, in-order responses.
interface ifetch_if;
  import ifetch_pkg::*;

  logic            mem_req_valid;
  logic            mem_req_ready;
  logic [ALEN-1:0] mem_req_addr;
  logic            mem_resp_valid;
  logic [ILEN-1:0] mem_resp_data;
  logic            mem_resp_error;

  modport master (
    output mem_req_valid, mem_req_addr,
    input  mem_req_ready, mem_resp_valid, mem_resp_data, mem_resp_error
  );

  modport slave (
    input  mem_req_valid, mem_req_addr,
    output mem_req_ready, mem_resp_valid, mem_resp_data, mem_resp_error
  );
endinterface

// File: rtl/ifetch_fetch_queue.sv
// Small synchronous FIFO of fetch entries; clear has priority over push/pop.
module ifetch_fetch_queue
  import ifetch_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic         i_clear,
  input  fetch_entry_t i_data,
  output fetch_entry_t o_head,
  output logic [CW-1:0] o_count,
  output logic         o_empty,
  output logic         o_full
);
  fetch_entry_t  r_mem [DEPTH];
  logic [PW-1:0] r_wr, r_rd;
  logic [CW-1:0] r_cnt;
  logic          w_push, w_pop;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign o_count = r_cnt;
  assign o_empty = (r_cnt == '0);
  assign o_full  = (r_cnt == CW'(DEPTH));
  assign o_head  = r_mem[r_rd];
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else if (i_clear) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= inc(r_wr);
      if (w_pop)  r_rd <= inc(r_rd);
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !i_clear) r_mem[r_wr] <= i_data;
  end
endmodule

// File: rtl/ifetch.sv
// Fetch stage: PC, credit-limited request issue, response queue, flush/redirect
// with stale-response dropping, and a halt on access faults or misaligned targets.
module ifetch
  import ifetch_pkg::*;
#(
  parameter logic [ALEN-1:0] RESET_PC     = '0,
  parameter int              FQ_DEPTH     = 2,
  parameter int              MAX_INFLIGHT = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic [ALEN-1:0] flush_target,
  input  logic            next_stalled,
  output logic            stall_next,
  output logic            ifetch_exception,
  output logic [ILEN-1:0] instruction,
  output logic [ALEN-1:0] instruction_addr,
  output logic [ALEN-1:0] instruction_next_addr,
  ifetch_if.master        mem
);
  localparam int IW = $clog2(MAX_INFLIGHT + 1);
  localparam int QW = $clog2(FQ_DEPTH + 1);
  localparam int SW = $clog2(MAX_INFLIGHT + FQ_DEPTH + 1) + 1;

  ifetch_state_t   r_state, w_state_nxt;
  logic [ALEN-1:0] r_pc, w_pc_nxt, r_resp_pc, w_resp_pc_nxt, r_mis_addr, w_mis_addr_nxt;
  logic [IW-1:0]   r_inflight, w_inflight_nxt, r_drop, w_drop_nxt;
  logic            r_mis_pend, w_mis_pend_nxt;

  fetch_entry_t    w_head, w_push_data;
  logic [QW-1:0]   w_q_count;
  logic            w_q_empty, w_q_full, w_push, w_pop, w_resp_push, w_mis_push;
  logic            w_req_valid, w_fire, w_resp, w_stale;
  logic [IW-1:0]   w_live;
  logic [SW-1:0]   w_used;

  assign w_resp  = mem.mem_resp_valid;
  assign w_stale = (r_drop != '0);
  assign w_pop   = !w_q_empty && !next_stalled;
  assign w_live  = r_inflight - r_drop;
  // Live requests plus queued words, net of this cycle's pop, must stay under
  // the queue depth; counting the pop keeps a free-running stream at 1 word/cycle.
  assign w_used  = SW'(w_live) + SW'(w_q_count) - SW'(w_pop);

  assign w_req_valid = !rst && (r_state == FETCH) && !flush &&
                       (r_inflight < IW'(MAX_INFLIGHT)) && (w_used < SW'(FQ_DEPTH));
  assign w_fire      = w_req_valid && mem.mem_req_ready;
  assign w_resp_push = w_resp && !w_stale && !flush;
  // Misaligned-target fault entry waits until every stale response is gone.
  assign w_mis_push  = r_mis_pend && !w_stale && !flush;
  assign w_push      = w_resp_push || w_mis_push;

  always_comb begin
    w_push_data           = '0;
    w_push_data.exception = mem.mem_resp_error;
    w_push_data.instr     = mem.mem_resp_data;
    w_push_data.addr      = r_resp_pc;
    if (w_mis_push) begin
      w_push_data.exception = 1'b1;
      w_push_data.instr     = '0;
      w_push_data.addr      = r_mis_addr;
    end
  end

  ifetch_fetch_queue #(.DEPTH(FQ_DEPTH)) u_fq (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_clear (flush),
    .i_data  (w_push_data),
    .o_head  (w_head),
    .o_count (w_q_count),
    .o_empty (w_q_empty),
    .o_full  (w_q_full)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_resp_pc_nxt  = r_resp_pc;
    w_inflight_nxt = r_inflight + IW'(w_fire) - IW'(w_resp);
    w_drop_nxt     = r_drop;
    w_mis_pend_nxt = r_mis_pend;
    w_mis_addr_nxt = r_mis_addr;
    if (flush) begin
      w_pc_nxt       = {flush_target[ALEN-1:2], 2'b00};
      w_resp_pc_nxt  = {flush_target[ALEN-1:2], 2'b00};
      w_drop_nxt     = r_inflight - IW'(w_resp);
      w_mis_pend_nxt = |flush_target[1:0];
      w_mis_addr_nxt = flush_target;
      w_state_nxt    = (|flush_target[1:0]) ? HALTED : FETCH;
    end else begin
      if (w_fire) w_pc_nxt = r_pc + ALEN'(4);
      if (w_resp && w_stale) w_drop_nxt = r_drop - IW'(1);
      if (w_resp_push) begin
        w_resp_pc_nxt = r_resp_pc + ALEN'(4);
        if (mem.mem_resp_error) w_state_nxt = HALTED;
      end
      if (w_mis_push) w_mis_pend_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= FETCH;
      r_pc       <= RESET_PC;
      r_resp_pc  <= RESET_PC;
      r_inflight <= '0;
      r_drop     <= '0;
      r_mis_pend <= 1'b0;
      r_mis_addr <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_resp_pc  <= w_resp_pc_nxt;
      r_inflight <= w_inflight_nxt;
      r_drop     <= w_drop_nxt;
      r_mis_pend <= w_mis_pend_nxt;
      r_mis_addr <= w_mis_addr_nxt;
    end
  end

  assign mem.mem_req_valid     = w_req_valid;
  assign mem.mem_req_addr      = r_pc;
  assign stall_next            = w_q_empty;
  assign ifetch_exception      = w_head.exception;
  assign instruction           = w_head.instr;
  assign instruction_addr      = w_head.addr;
  assign instruction_next_addr = w_head.addr + ALEN'(4);

  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(w_resp_push && w_q_full));
endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch with a fixed-latency in-order memory model.
module tb_ifetch;
  import ifetch_pkg::*;

  typedef struct { int due; logic [31:0] addr; } mreq_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            flush = 1'b0;
  logic            next_stalled = 1'b0;
  logic [ALEN-1:0] flush_target = '0;
  logic            stall_next, ifetch_exception;
  logic [ILEN-1:0] instruction;
  logic [ALEN-1:0] instruction_addr, instruction_next_addr;

  ifetch_if mem();

  ifetch #(.RESET_PC(32'h100), .FQ_DEPTH(2), .MAX_INFLIGHT(2)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .flush                 (flush),
    .flush_target          (flush_target),
    .next_stalled          (next_stalled),
    .stall_next            (stall_next),
    .ifetch_exception      (ifetch_exception),
    .instruction           (instruction),
    .instruction_addr      (instruction_addr),
    .instruction_next_addr (instruction_next_addr),
    .mem                   (mem)
  );

  always #5 clk = ~clk;

  int          nvec = 0, nerr = 0, cyc = 0, lat = 1, nfire = 0;
  logic        err_en = 1'b0;
  logic [31:0] err_addr = '0;
  mreq_t       pq[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, want %h", tag, got, exp);
    end
  endtask

  task automatic drv(input logic ns, input logic fl, input logic [31:0] tgt);
    next_stalled = ns;
    flush        = fl;
    flush_target = tgt;
    #1;
  endtask

  // Records this cycle's fire, crosses the edge, then presents any due response.
  task automatic tick();
    mreq_t m;
    if (mem.mem_req_valid && mem.mem_req_ready) begin
      m.due  = cyc + lat;
      m.addr = mem.mem_req_addr;
      pq.push_back(m);
      nfire++;
    end
    @(posedge clk); #1;
    cyc++;
    mem.mem_resp_valid = 1'b0;
    mem.mem_resp_error = 1'b0;
    mem.mem_resp_data  = '0;
    if (pq.size() != 0 && pq[0].due <= cyc) begin
      m = pq.pop_front();
      mem.mem_resp_valid = 1'b1;
      mem.mem_resp_data  = {16'hC0DE, m.addr[15:0]};
      mem.mem_resp_error = err_en && (m.addr == err_addr);
    end
  endtask

  task automatic do_reset(input int l);
    rst = 1'b1;
    flush = 1'b0; next_stalled = 1'b0; flush_target = '0;
    err_en = 1'b0; lat = l;
    mem.mem_req_ready = 1'b1; mem.mem_resp_valid = 1'b0;
    mem.mem_resp_error = 1'b0; mem.mem_resp_data = '0;
    pq.delete();
    @(posedge clk); @(posedge clk); #1;
    chk("rst_stall", 32'(stall_next), 1);
    chk("rst_vld", 32'(mem.mem_req_valid), 0);
    rst = 1'b0;
    cyc = 0; nfire = 0;
  endtask

  initial begin
    // streaming, 1-cycle memory
    do_reset(1);
    drv(0, 0, 0);
    chk("s_c0_vld", 32'(mem.mem_req_valid), 1);
    chk("s_c0_addr", mem.mem_req_addr, 32'h100);
    tick();
    drv(0, 0, 0);
    chk("s_c1_stall", 32'(stall_next), 1);
    chk("s_c1_addr", mem.mem_req_addr, 32'h104);
    tick();
    for (int i = 0; i < 3; i++) begin
      drv(0, 0, 0);
      chk("s_stall", 32'(stall_next), 0);
      chk("s_addr", instruction_addr, 32'(32'h100 + 4 * i));
      chk("s_next", instruction_next_addr, 32'(32'h104 + 4 * i));
      chk("s_data", instruction, 32'(32'hC0DE0100 + 4 * i));
      chk("s_exc", 32'(ifetch_exception), 0);
      tick();
    end

    // backpressure: decode stalled 5 cycles
    do_reset(1);
    for (int i = 0; i < 5; i++) begin
      drv(1, 0, 0);
      if (i >= 2) chk("bp_vld", 32'(mem.mem_req_valid), 0);
      if (i == 4) chk("bp_head", instruction_addr, 32'h100);
      tick();
    end
    chk("bp_fires", 32'(nfire), 2);
    for (int i = 0; i < 3; i++) begin
      drv(0, 0, 0);
      chk("bp_stall", 32'(stall_next), 0);
      chk("bp_addr", instruction_addr, 32'(32'h100 + 4 * i));
      chk("bp_data", instruction, 32'(32'hC0DE0100 + 4 * i));
      tick();
    end

    // flush with two requests in flight, 3-cycle memory
    do_reset(3);
    drv(0, 0, 0); tick();
    drv(0, 0, 0); tick();
    drv(0, 1, 32'h200); tick();
    drv(0, 0, 0);
    chk("fl_stall", 32'(stall_next), 1);
    tick();
    drv(0, 0, 0);
    chk("fl_rvld", 32'(mem.mem_req_valid), 1);
    chk("fl_raddr", mem.mem_req_addr, 32'h200);
    tick();
    drv(0, 0, 0);
    for (int n = 0; n < 10 && stall_next; n++) begin
      tick();
      drv(0, 0, 0);
    end
    chk("fl_arrive", 32'(stall_next), 0);
    chk("fl_cyc", 32'(cyc), 8);
    chk("fl_addr", instruction_addr, 32'h200);
    chk("fl_data", instruction, 32'hC0DE0200);
    chk("fl_exc", 32'(ifetch_exception), 0);
    tick();
    drv(0, 0, 0);
    chk("fl_addr2", instruction_addr, 32'h204);
    tick();

    // misaligned redirect, 2-cycle memory
    do_reset(2);
    drv(1, 0, 0); tick();
    drv(1, 1, 32'h202);
    chk("ma_vld_fl", 32'(mem.mem_req_valid), 0);
    tick();
    drv(1, 0, 0);
    chk("ma_stall2", 32'(stall_next), 1);
    chk("ma_vld2", 32'(mem.mem_req_valid), 0);
    tick();
    drv(1, 0, 0);
    chk("ma_stall3", 32'(stall_next), 1);
    tick();
    drv(1, 0, 0);
    chk("ma_stall4", 32'(stall_next), 0);
    chk("ma_exc", 32'(ifetch_exception), 1);
    chk("ma_addr", instruction_addr, 32'h202);
    chk("ma_next", instruction_next_addr, 32'h206);
    chk("ma_vld4", 32'(mem.mem_req_valid), 0);
    tick();
    drv(0, 0, 0);
    chk("ma_hold", instruction_addr, 32'h202);
    tick();
    drv(0, 0, 0);
    chk("ma_empty", 32'(stall_next), 1);
    chk("ma_vld6", 32'(mem.mem_req_valid), 0);
    tick();
    drv(0, 1, 32'h300); tick();
    drv(0, 0, 0);
    chk("ma_resume", 32'(mem.mem_req_valid), 1);
    chk("ma_raddr", mem.mem_req_addr, 32'h300);
    tick();

    // access fault on 'h108
    do_reset(1);
    err_en = 1'b1; err_addr = 32'h108;
    for (int i = 0; i < 4; i++) begin drv(0, 0, 0); tick(); end
    drv(0, 0, 0);
    chk("af_exc", 32'(ifetch_exception), 1);
    chk("af_addr", instruction_addr, 32'h108);
    chk("af_vld", 32'(mem.mem_req_valid), 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drv(0, 0, 0);
      chk("af_halt", 32'(mem.mem_req_valid), 0);
      tick();
    end
    chk("af_fires", 32'(nfire), 4);
    drv(0, 1, 32'h0); tick();
    drv(0, 0, 0);
    chk("af_rvld", 32'(mem.mem_req_valid), 1);
    chk("af_raddr", mem.mem_req_addr, 32'h0);
    tick();
    drv(0, 0, 0); tick();
    drv(0, 0, 0);
    chk("af_stall", 32'(stall_next), 0);
    chk("af_naddr", instruction_addr, 32'h0);
    chk("af_ndata", instruction, 32'hC0DE0000);
    chk("af_nexc", 32'(ifetch_exception), 0);
    tick();

    // async reset mid-stream
    do_reset(1);
    for (int i = 0; i < 3; i++) begin drv(0, 0, 0); tick(); end
    drv(0, 0, 0);
    chk("ar_live", 32'(stall_next), 0);
    rst = 1'b1;
    #1;
    chk("ar_stall", 32'(stall_next), 1);
    chk("ar_vld", 32'(mem.mem_req_valid), 0);
    pq.delete();
    mem.mem_resp_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    cyc = 0; nfire = 0;
    drv(0, 0, 0);
    chk("ar_rvld", 32'(mem.mem_req_valid), 1);
    chk("ar_raddr", mem.mem_req_addr, 32'h100);
    tick();
    drv(0, 0, 0); tick();
    drv(0, 0, 0);
    chk("ar_addr", instruction_addr, 32'h100);
    chk("ar_data", instruction, 32'hC0DE0100);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/ifetch.md
Name: ifetch

Overview:
- Instruction fetch stage, directly upstream of decode.
- Holds the PC and issues in-order 32-bit fetch requests to the instruction memory port.
- Buffers responses in a small fetch queue and presents one instruction per cycle to decode, with the standard stall handshake: stall_next out, next_stalled in from decode's stall_prev.
- Handles flush/redirect by discarding stale in-flight responses.

Parameters:
RESET_PC, 'h0, PC fetched first after reset; must be 4-byte aligned.
FQ_DEPTH, 2, fetch queue entries; also the bound on live requests plus queued entries.
MAX_INFLIGHT, 2, max outstanding memory requests, stale ones included.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
flush  in  1  redirect request (from exec/writeback)
flush_target  in  `ALEN  new PC on flush
next_stalled  in  1  decode cannot accept this cycle
stall_next  out  1  no valid instruction presented
ifetch_exception  out  1  fetch fault for presented entry
instruction  out  `ILEN  fetched word
instruction_addr  out  `ALEN  PC of presented word
instruction_next_addr  out  `ALEN  instruction_addr + 4
mem_req_valid  out  1  fetch request
mem_req_ready  in  1  memory accepts request
mem_req_addr  out  `ALEN  aligned fetch address
mem_resp_valid  in  1  response, in order, ≥1 cycle after accept
mem_resp_data  in  `ILEN  fetched data
mem_resp_error  in  1  access fault

Behaviour:
- Reset (async, all state):
  - pc = resp_pc = RESET_PC.
  - inflight = drop_cnt = 0; queue empty; state FETCH.
  - stall_next = 1, mem_req_valid = 0.
  - Data outputs are don't-care whenever stall_next = 1; the bench must not check them.
- Request issue:
  - mem_req_valid = (state == FETCH) && !flush && inflight < MAX_INFLIGHT && (inflight - drop_cnt) + q_count < FQ_DEPTH.
  - mem_req_addr = pc.
  - Fire = valid && ready: pc += 4 (wraps modulo 2^ALEN), inflight++.
  - mem_req_valid may deassert without a fire; memory must not rely on request stability.
- Response handling:
  - If drop_cnt > 0: response discarded, drop_cnt--.
  - Otherwise: push {mem_resp_error, mem_resp_data, resp_pc}; resp_pc += 4.
  - inflight-- on every response.
  - Credit rule guarantees the queue is never full on a live response; overflow is an assertion failure.
  - If mem_resp_error = 1: state → HALTED and no further requests.
- Output:
  - Queue head drives ifetch_exception, instruction, instruction_addr; instruction_next_addr = head addr + 4.
  - stall_next = queue empty.
  - Pop when !stall_next && !next_stalled.
  - Push and pop in the same cycle are both honoured.
- Latency: request fired at cycle t, response at t+1 → stall_next = 0 at t+2.
- Flush (highest priority):
  - pc = resp_pc = {flush_target[ALEN-1:2], 2'b00}.
  - Queue cleared, including any same-cycle push or pop.
  - drop_cnt = inflight count after this cycle's response (no request fires in a flush cycle).
  - state → FETCH; stall_next = 1 at t+1; first request to the target may fire at t+1.
- Misaligned target (flush_target[1:0] != 0):
  - No request issued.
  - Enqueue {exception = 1, instr = 'x, addr = flush_target} once stale responses have drained.
  - state → HALTED.
- HALTED: only a flush leaves it; queued entries continue to drain to decode.
- Simultaneous flush and response: the response is counted as stale and dropped.
- Reset mid-operation: all state cleared asynchronously; the memory side must also be reset, since in-flight responses are not tracked across reset.

Decomposition:
- Package ifetch_types: typedef struct packed {logic exception; logic [`ILEN-1:0] instr; logic [`ALEN-1:0] addr;} fetch_entry_t, plus typedef enum {FETCH, HALTED} ifetch_state_t.
- Sub-module fetch_queue:
  - Sync FIFO of fetch_entry_t, FQ_DEPTH entries.
  - Ports: push/pop/clear, head, count, empty/full.
  - Async reset to empty.

Test Plan:
- Streaming: reset with RESET_PC = 'h100, memory 1-cycle latency, next_stalled = 0 → instruction_addr 'h100, 'h104, 'h108 on consecutive cycles from t+2; instruction_next_addr = addr + 4.
- Backpressure: hold next_stalled = 1 for 5 cycles → at most FQ_DEPTH (2) words queued; no request fires while credits are exhausted; release → 'h100, 'h104 delivered in order with no loss or duplication.
- Flush with 2 in flight: flush_target = 'h200 while 2 responses are pending → both discarded; next presented addr = 'h200 with its data; stall_next = 1 the cycle after the flush.
- Misaligned target: flush_target = 'h202 → single entry with ifetch_exception = 1, addr = 'h202; mem_req_valid stays 0 until the next flush.
- Access fault: mem_resp_error on the 'h108 fetch → entry 'h108 has ifetch_exception = 1; no further requests; a flush to 'h0 resumes fetching.
- Async reset asserted mid-stream → stall_next = 1 and mem_req_valid = 0 immediately without a clock edge; fetch restarts at RESET_PC.
